// File: rtl/timer_count_core.sv
// timer_count_core
// Seconds counter for the two-mode timer. Counts up (stopwatch) or down from a
// loaded preset, holding the value in 0..99 so it can drive the binary-to-BCD
// converter directly.
//
// Parameters:
//   TICK_DIV   clock cycles per count step (>= 2)
// Ports:
//   Clock      system clock, rising edge
//   Resetn     asynchronous active-low reset
//   Mode       0 = count up, 1 = count down; latched on a start from IDLE
//   StartStop  level; each rising edge is one start/stop request
//   Clear      synchronous clear, level-sensitive
//   Load       one-cycle strobe, writes clamped LoadValue to preset and count
//   LoadValue  preset value, clamped to 99
//   Binary     current count 0..99
//   Running    high while counting
//   Done       high once the final value (99 or 0) has been reached
module timer_count_core #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Mode,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       Load,
    input  logic [7:0] LoadValue,
    output logic [7:0] Binary,
    output logic       Running,
    output logic       Done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    preset_q, preset_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          mode_q, mode_d;
    logic          hist_q;
    logic          running_q, done_q;

    logic       req;
    logic       tick;
    logic [7:0] load_val;
    logic [7:0] reload_val;

    assign req        = StartStop & ~hist_q;
    assign tick       = (pre_q == PRE_MAX);
    assign load_val   = (LoadValue > 8'd99) ? 8'd99 : LoadValue;
    // Clear and DONE-exit return to the starting point of the last run's direction.
    assign reload_val = mode_q ? preset_q : 8'd0;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        pre_d    = pre_q;
        mode_d   = mode_q;

        if (Clear) begin
            state_d = StIdle;
            count_d = reload_val;
            pre_d   = '0;
        end else if (Load && (state_q != StRun)) begin
            preset_d = load_val;
            count_d  = load_val;
            state_d  = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A start that could only reach its end value immediately is refused.
                    if (req && !(Mode ? (count_q == 8'd0) : (count_q == 8'd99))) begin
                        mode_d  = Mode;
                        pre_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (req) begin
                        state_d = StPause;
                    end
                    // The tick still lands on a stop edge; reaching the end overrides PAUSE.
                    if (tick) begin
                        if (mode_q) begin
                            if (count_q != 8'd0) begin
                                count_d = count_q - 8'd1;
                            end
                            if (count_q <= 8'd1) begin
                                state_d = StDone;
                            end
                        end else begin
                            if (count_q < 8'd99) begin
                                count_d = count_q + 8'd1;
                            end
                            if (count_q >= 8'd98) begin
                                state_d = StDone;
                            end
                        end
                    end
                end
                StPause: begin
                    if (req) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (req) begin
                        state_d = StIdle;
                        count_d = reload_val;
                        pre_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            count_q   <= 8'd0;
            preset_q  <= 8'd0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            hist_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            preset_q  <= preset_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            hist_q    <= StartStop;
            running_q <= (state_d == StRun);
            done_q    <= (state_d == StDone);
        end
    end

    assign Binary  = count_q;
    assign Running = running_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_timer_count_core.sv
// Bench for timer_count_core with TICK_DIV = 4: a table of directed steps with
// expected outputs, a mid-run asynchronous reset, then random stimulus checked
// every cycle against a behavioural model of the timer.
module tb_timer_count_core;

    localparam int TD = 4;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Mode = 1'b0;
    logic       StartStop = 1'b0;
    logic       Clear = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadValue = 8'd0;
    logic [7:0] Binary;
    logic       Running;
    logic       Done;

    int total = 0;
    int bad = 0;

    timer_count_core #(.TICK_DIV(TD)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Mode     (Mode),
        .StartStop(StartStop),
        .Clear    (Clear),
        .Load     (Load),
        .LoadValue(LoadValue),
        .Binary   (Binary),
        .Running  (Running),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: a phase name, the count, the preset, cycles spent in the
    // current count period, the direction of the current run, the last StartStop.
    typedef enum {MIdle, MRun, MPause, MDone} mphase_e;
    mphase_e m_phase;
    int      m_count, m_preset, m_elapsed;
    bit      m_down, m_hist;

    task automatic model_reset();
        m_phase = MIdle; m_count = 0; m_preset = 0; m_elapsed = 0;
        m_down = 1'b0; m_hist = 1'b0;
    endtask

    task automatic model_step();
        bit req;
        int target;
        req    = StartStop && !m_hist;
        m_hist = StartStop;
        if (Clear) begin
            m_phase = MIdle;
            m_count = m_down ? m_preset : 0;
            m_elapsed = 0;
        end else if (Load && m_phase != MRun) begin
            m_preset = (int'(LoadValue) > 99) ? 99 : int'(LoadValue);
            m_count = m_preset;
            m_phase = MIdle;
        end else if (m_phase == MIdle) begin
            target = Mode ? 0 : 99;
            if (req && m_count != target) begin
                m_down = Mode; m_elapsed = 0; m_phase = MRun;
            end
        end else if (m_phase == MRun) begin
            m_elapsed = (m_elapsed + 1) % TD;
            if (m_elapsed == 0) m_count = m_down ? m_count - 1 : m_count + 1;
            if (req) m_phase = MPause;
            if (m_count == (m_down ? 0 : 99)) m_phase = MDone;
        end else if (m_phase == MPause) begin
            if (req) m_phase = MRun;
        end else begin
            if (req) begin
                m_phase = MIdle; m_count = m_down ? m_preset : 0; m_elapsed = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        model_step();
        #1;
        chk("model_binary", int'(Binary), m_count);
        chk("model_running", int'(Running), int'(m_phase == MRun));
        chk("model_done", int'(Done), int'(m_phase == MDone));
        total++;
        if (Binary > 8'd99) begin
            bad++;
            $display("FAIL binary_range: got %0d expected <= 99", Binary);
        end
    endtask

    typedef struct {
        logic       ss, clr, ld, mode;
        logic [7:0] lv;
        int         n;
        int         eb;
        logic       er, ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ss, input logic clr, input logic ld, input logic mode,
                       input logic [7:0] lv, input int n, input int eb, input logic er,
                       input logic ed);
        vec_t v;
        v.ss = ss; v.clr = clr; v.ld = ld; v.mode = mode; v.lv = lv;
        v.n = n; v.eb = eb; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        //   ss clr ld md  lv    n    bin run done
        add(1, 0, 0, 0, 8'd0,   1,   0, 1, 0);  // start up
        add(0, 0, 0, 0, 8'd0,   3,   0, 1, 0);
        add(0, 0, 0, 0, 8'd0,   1,   1, 1, 0);  // 4 cycles after start
        add(0, 0, 0, 0, 8'd0,  16,   5, 1, 0);  // 20 cycles after start
        add(0, 0, 0, 0, 8'd0, 376,  99, 0, 1);  // reaches 99
        add(0, 0, 0, 0, 8'd0,   8,  99, 0, 1);  // holds
        add(1, 0, 0, 0, 8'd0,   1,   0, 0, 0);  // request in DONE
        add(0, 0, 1, 1, 8'd120, 1,  99, 0, 0);  // load clamps
        add(0, 0, 1, 1, 8'd3,   1,   3, 0, 0);
        add(1, 0, 0, 1, 8'd0,   1,   3, 1, 0);  // start down
        add(0, 0, 0, 1, 8'd0,   3,   3, 1, 0);
        add(0, 0, 0, 1, 8'd0,   1,   2, 1, 0);
        add(0, 0, 0, 1, 8'd0,   4,   1, 1, 0);
        add(0, 0, 0, 1, 8'd0,   4,   0, 0, 1);  // done with 0
        add(1, 0, 0, 1, 8'd0,   1,   3, 0, 0);  // reload preset
        add(0, 0, 1, 1, 8'd0,   1,   0, 0, 0);
        add(1, 0, 0, 1, 8'd0,   1,   0, 0, 0);  // down from 0 refused
        add(0, 0, 0, 1, 8'd0,   1,   0, 0, 0);
        add(1, 0, 0, 0, 8'd0,   1,   0, 1, 0);  // start up
        add(1, 0, 0, 0, 8'd0,   6,   1, 1, 0);  // held high: one request
        add(0, 0, 0, 1, 8'd0,   4,   2, 1, 0);  // Mode toggled in RUN
        add(0, 0, 1, 0, 8'd50,  1,   2, 1, 0);  // Load in RUN ignored
        add(0, 0, 0, 0, 8'd0,   1,   3, 1, 0);
        add(0, 0, 0, 0, 8'd0,   1,   3, 1, 0);
        add(1, 0, 0, 0, 8'd0,   1,   3, 0, 0);  // pause 2 into period
        add(0, 0, 0, 0, 8'd0,  10,   3, 0, 0);  // frozen
        add(1, 0, 0, 0, 8'd0,   1,   3, 1, 0);  // resume
        add(0, 0, 0, 0, 8'd0,   1,   3, 1, 0);
        add(0, 0, 0, 0, 8'd0,   1,   4, 1, 0);  // 2 cycles after resume
        add(0, 0, 0, 0, 8'd0,   3,   4, 1, 0);
        add(1, 0, 0, 0, 8'd0,   1,   5, 0, 0);  // request on tick
        add(0, 1, 1, 0, 8'd7,   1,   0, 0, 0);  // Clear beats Load
        add(0, 0, 1, 0, 8'd20,  1,  20, 0, 0);
        add(1, 0, 0, 1, 8'd0,   1,  20, 1, 0);
        add(0, 1, 1, 0, 8'd7,   1,  20, 0, 0);  // preset untouched
        add(0, 1, 0, 0, 8'd0,   1,  20, 0, 0);
        add(0, 0, 0, 0, 8'd0,   1,  20, 0, 0);
        add(0, 0, 1, 1, 8'd1,   1,   1, 0, 0);
        add(1, 0, 0, 1, 8'd0,   1,   1, 1, 0);
        add(0, 0, 0, 1, 8'd0,   3,   1, 1, 0);
        add(1, 0, 0, 1, 8'd0,   1,   0, 0, 1);  // final tick beats request
        add(0, 0, 0, 1, 8'd0,   1,   0, 0, 1);
        add(1, 0, 1, 1, 8'd5,   1,   5, 0, 0);  // Load beats request
        add(1, 0, 0, 1, 8'd0,   1,   5, 0, 0);  // edge was consumed
        add(0, 0, 0, 1, 8'd0,   1,   5, 0, 0);
        add(0, 0, 1, 0, 8'd99,  1,  99, 0, 0);
        add(1, 0, 0, 0, 8'd0,   1,  99, 0, 0);  // up from 99 refused
        add(0, 0, 0, 0, 8'd0,   1,  99, 0, 0);

        model_reset();
        #1;
        chk("reset_binary", int'(Binary), 0);
        chk("reset_running", int'(Running), 0);
        chk("reset_done", int'(Done), 0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;

        foreach (vecs[i]) begin
            StartStop = vecs[i].ss; Clear = vecs[i].clr; Load = vecs[i].ld;
            Mode = vecs[i].mode; LoadValue = vecs[i].lv;
            for (int k = 0; k < vecs[i].n; k++) cyc();
            chk($sformatf("vec%0d_binary", i), int'(Binary), vecs[i].eb);
            chk($sformatf("vec%0d_running", i), int'(Running), int'(vecs[i].er));
            chk($sformatf("vec%0d_done", i), int'(Done), int'(vecs[i].ed));
        end

        // Reset asserted mid-run, between clock edges.
        StartStop = 0; Clear = 0; Load = 1; Mode = 1; LoadValue = 8'd30;
        cyc();
        Load = 0; StartStop = 1;
        cyc();
        StartStop = 0;
        for (int k = 0; k < 5; k++) cyc();
        chk("midrun_binary", int'(Binary), 29);
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        chk("async_reset_binary", int'(Binary), 0);
        chk("async_reset_running", int'(Running), 0);
        chk("async_reset_done", int'(Done), 0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        chk("after_reset_binary", int'(Binary), 0);
        chk("after_reset_running", int'(Running), 0);

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) StartStop = ~StartStop;
            Clear = ($urandom_range(0, 59) == 0);
            Load = ($urandom_range(0, 29) == 0);
            Mode = 1'($urandom_range(0, 1));
            LoadValue = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) LoadValue = 8'($urandom_range(0, 6));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_count_core.md
# timer_count_core

Timing core of the two-mode timer: counts seconds up (stopwatch) or down (countdown from a loaded preset) and presents the current value 0–99 as an 8-bit binary word. Sits directly upstream of `DoubleDabble8Bit`; its `Binary` output drives that converter's input unchanged. Start/stop, clear and load come from debounced, clock-synchronous controls.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per count step (1 s at 50 MHz); legal range ≥ 2.
- `Clock`  in  1  system clock; all state on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Mode`  in  1  0 = count up (stopwatch), 1 = count down (timer); sampled only in IDLE.
- `StartStop`  in  1  level; each rising edge is one start/stop request.
- `Clear`  in  1  synchronous clear, level-sensitive.
- `Load`  in  1  one-cycle strobe, writes `LoadValue` to preset and count.
- `LoadValue`  in  8  preset, unsigned; values > 99 clamp to 99.
- `Binary`  out  8  current count, always 0–99; feeds `DoubleDabble8Bit`.
- `Running`  out  1  high in RUN.
- `Done`  out  1  high in DONE.

## Operation
- Registers: 2-bit state, 8-bit count, 8-bit preset, prescaler of width ceil(log2(TICK_DIV)), latched mode, StartStop history bit.
- States: IDLE, RUN, PAUSE, DONE.
- Edge detect: request when `StartStop`=1 and history=0; history updated every cycle, including in states that ignore the request.
- Control priority per cycle: `Clear` > `Load` > start/stop request > tick.
- Clear (any state): go IDLE; count ← 0 if latched mode is up, else ← preset; prescaler ← 0.
- Load (IDLE, PAUSE, DONE only; ignored in RUN): preset ← min(LoadValue, 99); count ← same; go IDLE.
- IDLE + request: latch `Mode`, prescaler ← 0, go RUN. Exceptions: down mode with count = 0, or up mode with count = 99 → request ignored, stay IDLE.
- RUN: prescaler increments; at TICK_DIV−1 it wraps to 0 and a tick occurs. Up: count+1; count reaching 99 → DONE. Down: count−1; count reaching 0 → DONE. Request → PAUSE.
- PAUSE: prescaler and count hold; request → RUN, prescaler resumes from its held value.
- DONE: count holds (99 or 0); request → IDLE with count reloaded as for Clear.
- Count never leaves 0–99: no wrap, no underflow.
- `Mode` changes outside IDLE have no effect until the next start from IDLE.

## Timing
- Reset (`Resetn`=0, asynchronous): state IDLE, `Binary`=0, preset 0, prescaler 0, history 0, latched mode 0, `Running`=0, `Done`=0. Outputs take these values immediately, without waiting for a clock edge.
- All outputs are registered.
- Request latency: `StartStop` rises before edge N; state and `Running` change at edge N.
- Tick latency: the first count change after a start occurs exactly TICK_DIV clock edges after the start edge. Subsequent changes occur every TICK_DIV edges.
- `Done` rises on the same edge where the final count value (0 or 99) appears on `Binary`.
- Reset asserted mid-RUN: counting aborts; after release the block is in IDLE with count 0 and needs a fresh request.
- Same-cycle conflicts:
  - `Clear`+`Load`: Clear wins; preset is unchanged.
  - `Load`+request: Load wins; the edge is consumed (history updates).
  - Request coinciding with a tick in RUN: go PAUSE and the tick's count update still applies.
  - Final tick coinciding with a request: DONE wins.

## Test plan
- Reset → `Binary`=0, `Running`=0, `Done`=0. Assert `Resetn` mid-RUN → same values asynchronously; stays IDLE after release.
- TICK_DIV=4, Mode=0, start → `Binary` is 1 after 4 cycles and 5 after 20 cycles; continuing → reaches 99, `Done`=1, `Running`=0, count holds; a further request → IDLE, `Binary`=0.
- Mode=1, Load 120 → `Binary`=99. Then Load 3 and start → 2, 1, 0 at 4-cycle spacing; `Done` rises with 0. A request in DONE → `Binary`=3.
- Pause/resume: stop 2 cycles into a tick period, hold 10 cycles → count frozen. Resume → next change exactly 2 cycles later.
- Ignored starts:
  - Mode=1, count 0 → stays IDLE.
  - Load during RUN → no effect.
  - `Mode` toggled during RUN → direction unchanged.
  - `StartStop` held high → only one request.
- Priority: Clear+Load same cycle → IDLE, preset unchanged. Request on a tick edge → PAUSE with the updated count. Bench checks `Binary` ≤ 99 every cycle.
